matvec_stream_ctrl: RTL



---
 rtl/matvec_pkg.sv | 33 +++
 rtl/matvec_stream_ctrl_if.sv | 27 ++
 rtl/matvec_dot_lane.sv | 42 ++++
 rtl/matvec_stream_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/matvec_pkg.sv
// rtl/matvec_pkg.sv - shared FSM type, index-width helper and output saturation for the matvec engine
package matvec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Saturation works on a fixed-width signed view; accumulators up to this width are supported.
  localparam int SAT_W = 64;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [SAT_W-1:0] saturate(input logic [SAT_W-1:0] value, input int elem_w);
    logic signed [SAT_W-1:0] v;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    v  = $signed(value);
    hi = (64'sd1 <<< (elem_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (elem_w - 1));
    if (v > hi)
      return hi;
    else if (v < lo)
      return lo;
    else
      return v;
  endfunction

endpackage

// File: rtl/matvec_stream_ctrl_if.sv
// rtl/matvec_stream_ctrl_if.sv - input beat stream and result stream handshakes of the matvec engine
interface matvec_stream_ctrl_if #(
  parameter int ELEM_W = 32,
  parameter int NI     = 8,
  parameter int LANES  = 4
);
  localparam int BEAT_W = LANES * NI * ELEM_W;

  logic              in_valid;
  logic              in_ready;
  logic [BEAT_W-1:0] in_a;
  logic [BEAT_W-1:0] in_x;
  logic              out_valid;
  logic              out_ready;
  logic [ELEM_W-1:0] out_data;
  logic              out_last;

  modport master (
    output in_valid, in_a, in_x, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_a, in_x, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/matvec_dot_lane.sv
// rtl/matvec_dot_lane.sv - one dot-product lane: NI signed multipliers, beat sum, wrapping accumulator
module matvec_dot_lane #(
  parameter int ELEM_W = 32,
  parameter int NI     = 8,
  parameter int ACC_W  = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 en,
  input  logic [NI*ELEM_W-1:0] a,
  input  logic [NI*ELEM_W-1:0] x,
  output logic [ACC_W-1:0]     acc
);

  logic [ACC_W-1:0] term [NI];
  logic [ACC_W-1:0] beat_sum;

  for (genvar k = 0; k < NI; k++) begin : g_mul
    logic signed [2*ELEM_W-1:0] prod;
    assign prod = (2*ELEM_W)'($signed(a[k*ELEM_W +: ELEM_W])) *
                  (2*ELEM_W)'($signed(x[k*ELEM_W +: ELEM_W]));
    // Signed cast sign-extends when ACC_W is wider and truncates when narrower.
    assign term[k] = ACC_W'(prod);
  end

  always_comb begin
    beat_sum = '0;
    for (int k = 0; k < NI; k++)
      beat_sum = beat_sum + term[k];
  end

  always_ff @(posedge clk) begin
    if (reset)
      acc <= '0;
    else if (clear)
      acc <= '0;
    else if (en)
      acc <= acc + beat_sum;
  end

endmodule

// File: rtl/matvec_stream_ctrl.sv
// rtl/matvec_stream_ctrl.sv - streaming y = A*x engine; OUT_SAT_EN adds output saturation and sat_flag
module matvec_stream_ctrl
  import matvec_pkg::*;
#(
  parameter int ELEM_W = 32,
  parameter int NI     = 8,
  parameter int LANES  = 4,
  parameter int ACC_W  = 64,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_rows,
  input  logic [CNT_W-1:0] chunks_per_row,
  matvec_stream_ctrl_if.slave io,
  output logic             busy,
  output logic             done
`ifdef OUT_SAT_EN
  ,
  output logic             sat_flag
`endif
);

  localparam int LIDX_W = idx_w(LANES);
  localparam int ROW_W  = CNT_W + 1;

  state_t state, state_next;

  logic [CNT_W-1:0]  rows_q;
  logic [CNT_W-1:0]  chunks_q;
  logic [CNT_W-1:0]  beat;
  logic [ROW_W-1:0]  row_base;
  logic [ROW_W-1:0]  rem;
  logic [LIDX_W-1:0] lane_idx;
  logic              out_valid_q;
  logic [ACC_W-1:0]  acc [LANES];
  logic [ACC_W-1:0]  acc_sel;

  logic start_op, accept, xfer, last_beat, last_lane, last_group, acc_clear;

  assign start_op   = (state == IDLE) && start;
  assign accept     = io.in_valid && io.in_ready;
  assign xfer       = out_valid_q && io.out_ready;
  assign last_beat  = (beat == chunks_q - CNT_W'(1));
  // Rows still owed from the current group onward; row_base is g*LANES.
  assign rem        = ROW_W'(rows_q) - row_base;
  assign last_lane  = (32'(lane_idx) == LANES - 1) || (ROW_W'(lane_idx) + ROW_W'(1) == rem);
  assign last_group = (rem <= ROW_W'(LANES));
  assign acc_clear  = start_op || (xfer && last_lane);

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (num_rows == '0) ? DONE : LOAD;
      LOAD:    if (accept && last_beat) state_next = DRAIN;
      DRAIN:   if (xfer && last_lane) state_next = last_group ? DONE : LOAD;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    io.in_ready = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state)
      IDLE:    busy = 1'b0;
      LOAD:    io.in_ready = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rows_q      <= '0;
      chunks_q    <= '0;
      beat        <= '0;
      row_base    <= '0;
      lane_idx    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= (state_next == DRAIN);
      if (start_op) begin
        rows_q   <= num_rows;
        chunks_q <= (chunks_per_row == '0) ? CNT_W'(1) : chunks_per_row;
        beat     <= '0;
        row_base <= '0;
        lane_idx <= '0;
      end
      if (accept)
        beat <= last_beat ? '0 : beat + CNT_W'(1);
      if (xfer) begin
        if (last_lane) begin
          lane_idx <= '0;
          row_base <= row_base + ROW_W'(LANES);
        end else begin
          lane_idx <= lane_idx + LIDX_W'(1);
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    matvec_dot_lane #(
      .ELEM_W (ELEM_W),
      .NI     (NI),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .clear (acc_clear),
      .en    (accept),
      .a     (io.in_a[l*NI*ELEM_W +: NI*ELEM_W]),
      .x     (io.in_x[l*NI*ELEM_W +: NI*ELEM_W]),
      .acc   (acc[l])
    );
  end

  // Accumulators and lane_idx are frozen during DRAIN, so the muxed output holds through stalls.
  assign acc_sel      = acc[lane_idx];
  assign io.out_valid = out_valid_q;
  assign io.out_last  = out_valid_q && last_group && last_lane;

`ifdef OUT_SAT_EN
  logic [SAT_W-1:0] acc_wide;
  logic [SAT_W-1:0] acc_clip;

  assign acc_wide    = SAT_W'($signed(acc_sel));
  assign acc_clip    = saturate(acc_wide, ELEM_W);
  assign io.out_data = acc_clip[ELEM_W-1:0];

  always_ff @(posedge clk) begin
    if (reset)
      sat_flag <= 1'b0;
    else if (start_op)
      sat_flag <= 1'b0;
    else if (xfer && (acc_clip != acc_wide))
      sat_flag <= 1'b1;
  end
`else
  assign io.out_data = acc_sel[ELEM_W-1:0];
`endif

endmodule
